// File: rtl/vram_arbiter.sv
// vram_arbiter
// Shares the external video/system memory bus between the CPU (default owner)
// and NREQ DMA masters. The CPU is parked through a HALT/BA handshake, then the
// DMA masters are served one at a time in round-robin order using the
// hold/bus_ready protocol.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   cpu_halt          request to the CPU to release the bus
//   cpu_ba            CPU bus-available acknowledge
//   cpu_addr, cpu_cs  CPU address / memory select
//   req, hold         per-master bus request / bus-in-use
//   bus_ready         per-master grant (one-hot or zero)
//   dma_addr, dma_cs  per-master address (16 bits each) / memory select
//   mem_addr, mem_cs  muxed memory bus
//   owner, owner_valid  index of the DMA master that owns the bus
//   timeout_err       sticky: a grant expired without hold being raised
module vram_arbiter #(
  parameter int NREQ     = 2,
  parameter int GRANT_TO = 15
) (
  input  logic               clk,
  input  logic               rst,
  output logic               cpu_halt,
  input  logic               cpu_ba,
  input  logic [15:0]        cpu_addr,
  input  logic               cpu_cs,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    hold,
  output logic [NREQ-1:0]    bus_ready,
  input  logic [16*NREQ-1:0] dma_addr,
  input  logic [NREQ-1:0]    dma_cs,
  output logic [15:0]        mem_addr,
  output logic               mem_cs,
  output logic [1:0]         owner,
  output logic               owner_valid,
  output logic               timeout_err
);

  typedef enum logic [2:0] {IDLE, HALT, GRANT, OWN, TURN} state_t;

  localparam logic [3:0] CNT_LAST = 4'(GRANT_TO - 1);

  state_t            state, state_nx;
  logic [1:0]        win, win_nx;
  logic [1:0]        last;
  logic [3:0]        cnt;
  logic [15:0]       addr_last;
  logic              expire;
  logic [NREQ-1:0]   win_oh, win_nx_oh, others;
  logic              hold_w, req_w, cs_w;
  logic [15:0]       addr_w;

  // Round-robin pick: first set bit strictly after 'from', wrapping, so that
  // 'from' itself has the lowest priority.
  function automatic logic [1:0] rr_pick(input logic [1:0] from,
                                         input logic [NREQ-1:0] mask);
    logic [1:0] pick;
    int         best;
    int         rank;
    pick = from;
    best = NREQ + 1;
    for (int i = 0; i < NREQ; i++) begin
      rank = (i > int'(from)) ? (i - int'(from)) : (i - int'(from) + NREQ);
      if (mask[i] && rank < best) begin
        best = rank;
        pick = 2'(i);
      end
    end
    return pick;
  endfunction

  // Signals of the current winner, selected through one-hot masks so the
  // index width never has to match the vector width.
  always_comb begin
    win_oh    = '0;
    win_nx_oh = '0;
    addr_w    = '0;
    for (int i = 0; i < NREQ; i++) begin
      win_oh[i]    = (win == 2'(i));
      win_nx_oh[i] = (win_nx == 2'(i));
      if (win == 2'(i)) addr_w = dma_addr[16*i +: 16];
    end
    hold_w = |(hold & win_oh);
    req_w  = |(req & win_oh);
    cs_w   = |(dma_cs & win_oh);
    others = req & ~win_oh;
  end

  // State register plus the registered outputs, which are derived from the
  // next state so that they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      win         <= '0;
      last        <= 2'(NREQ - 1);
      cnt         <= '0;
      bus_ready   <= '0;
      cpu_halt    <= 1'b0;
      owner       <= '0;
      owner_valid <= 1'b0;
      timeout_err <= 1'b0;
      addr_last   <= '0;
    end else begin
      state     <= state_nx;
      win       <= win_nx;
      // Counts GRANT cycles; any other state reloads it for the next grant.
      cnt       <= (state == GRANT) ? cnt + 4'd1 : 4'd0;
      addr_last <= mem_addr;
      if (state == OWN && state_nx == TURN) last <= win;
      if (expire) timeout_err <= 1'b1;
      bus_ready   <= (state_nx == GRANT || state_nx == OWN) ? win_nx_oh : '0;
      cpu_halt    <= (state_nx != IDLE);
      owner_valid <= (state_nx == OWN);
      if (state_nx == OWN) owner <= win_nx;
    end
  end

  // Next-state logic. Winner selection only happens in IDLE and TURN, so
  // requests raised during OWN simply wait.
  always_comb begin
    state_nx = state;
    win_nx   = win;
    expire   = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          win_nx   = rr_pick(last, req);
          state_nx = HALT;
        end
      end
      HALT: begin
        if (cpu_ba) state_nx = GRANT;
      end
      GRANT: begin
        if (hold_w) begin
          state_nx = OWN;
        end else if (cnt == CNT_LAST) begin
          expire   = 1'b1;
          state_nx = TURN;
        end else if (!req_w) begin
          state_nx = TURN;
        end
      end
      OWN: begin
        if (!hold_w) state_nx = TURN;
      end
      TURN: begin
        // The master just served only gets the bus again when nobody else
        // is asking; the CPU stays halted across back-to-back grants.
        if (|others) begin
          win_nx   = rr_pick(last, others);
          state_nx = GRANT;
        end else if (req_w) begin
          state_nx = GRANT;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Memory bus mux. Outside IDLE and OWN nobody drives chip-select and the
  // address is held at its last value.
  always_comb begin
    mem_addr = addr_last;
    mem_cs   = 1'b0;
    case (state)
      IDLE: begin
        mem_addr = cpu_addr;
        mem_cs   = cpu_cs;
      end
      OWN: begin
        mem_addr = addr_w;
        mem_cs   = cs_w;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus randomized
// request patterns checked against a round-robin model of the grant order.
module tb_vram_arbiter;
  localparam int NREQ = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               cpu_halt, cpu_ba, cpu_cs;
  logic [15:0]        cpu_addr;
  logic [NREQ-1:0]    req, hold, bus_ready, dma_cs;
  logic [16*NREQ-1:0] dma_addr;
  logic [15:0]        mem_addr;
  logic               mem_cs;
  logic [1:0]         owner;
  logic               owner_valid, timeout_err;

  int n_cmp = 0;
  int n_bad = 0;
  int m_last;

  vram_arbiter #(.NREQ(NREQ), .GRANT_TO(15)) dut (
    .clk(clk), .rst(rst), .cpu_halt(cpu_halt), .cpu_ba(cpu_ba),
    .cpu_addr(cpu_addr), .cpu_cs(cpu_cs), .req(req), .hold(hold),
    .bus_ready(bus_ready), .dma_addr(dma_addr), .dma_cs(dma_cs),
    .mem_addr(mem_addr), .mem_cs(mem_cs), .owner(owner),
    .owner_valid(owner_valid), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for a grant; an expired bound shows up as a failed grant check.
  task automatic wait_grant();
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (bus_ready != '0) break;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; hold = '0; dma_cs = '0;
    cyc();
    rst = 1'b0;
    m_last = NREQ - 1;
  endtask

  // Expected round-robin winner: first pending master after the last served.
  function automatic int rr_next(int last, logic [NREQ-1:0] pend);
    for (int k = 1; k <= NREQ; k++) begin
      if (pend[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return 0;
  endfunction

  task automatic test_reset();
    rst = 1'b1; cpu_ba = 1'b1; cpu_addr = 16'h2222; cpu_cs = 1'b1;
    req = '0; hold = '0; dma_addr = '0; dma_cs = '0;
    cyc(); cyc();
    rst = 1'b0;
    m_last = NREQ - 1;
    n_cmp++; if (cpu_halt !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_halt: got %b want 0", cpu_halt); end
    n_cmp++; if (bus_ready !== 2'b00) begin n_bad++; $display("[TB] FAIL reset_ready: got %b want 00", bus_ready); end
    n_cmp++; if (owner_valid !== 1'b0 || owner !== 2'd0) begin n_bad++; $display("[TB] FAIL reset_owner: got %b/%0d want 0/0", owner_valid, owner); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_timeout: got %b want 0", timeout_err); end
    n_cmp++; if (mem_addr !== 16'h2222 || mem_cs !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_mem: got %h/%b want 2222/1", mem_addr, mem_cs); end
  endtask

  task automatic test_single();
    cpu_ba = 1'b1; cpu_addr = 16'h0100; cpu_cs = 1'b1; req = 2'b01;
    cyc();
    n_cmp++; if (cpu_halt !== 1'b1 || bus_ready !== 2'b00 || mem_cs !== 1'b0) begin n_bad++; $display("[TB] FAIL single_halt: got halt=%b ready=%b cs=%b want 1/00/0", cpu_halt, bus_ready, mem_cs); end
    cyc();
    n_cmp++; if (bus_ready !== 2'b01) begin n_bad++; $display("[TB] FAIL single_grant: got %b want 01", bus_ready); end
    hold = 2'b01; req = 2'b00; dma_addr[15:0] = 16'h4000; dma_cs = 2'b01;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_cmp++; if (mem_addr !== 16'h4000 || mem_cs !== 1'b1 || owner_valid !== 1'b1 || owner !== 2'd0) begin n_bad++; $display("[TB] FAIL single_own: got %h/%b/%b/%0d want 4000/1/1/0", mem_addr, mem_cs, owner_valid, owner); end
    end
    hold = 2'b00;
    cyc();
    n_cmp++; if (bus_ready !== 2'b00 || mem_cs !== 1'b0 || cpu_halt !== 1'b1 || mem_addr !== 16'h4000) begin n_bad++; $display("[TB] FAIL single_turn: got ready=%b cs=%b halt=%b addr=%h want 00/0/1/4000", bus_ready, mem_cs, cpu_halt, mem_addr); end
    cyc();
    n_cmp++; if (cpu_halt !== 1'b0 || mem_addr !== 16'h0100 || mem_cs !== 1'b1) begin n_bad++; $display("[TB] FAIL single_idle: got halt=%b addr=%h cs=%b want 0/0100/1", cpu_halt, mem_addr, mem_cs); end
    m_last = 0;
  endtask

  task automatic test_ba_latency();
    cpu_ba = 1'b0; cpu_cs = 1'b1; req = 2'b01;
    cyc();
    n_cmp++; if (cpu_halt !== 1'b1) begin n_bad++; $display("[TB] FAIL ba_halt: got %b want 1", cpu_halt); end
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_cmp++; if (bus_ready !== 2'b00 || mem_cs !== 1'b0) begin n_bad++; $display("[TB] FAIL ba_wait: got ready=%b cs=%b want 00/0", bus_ready, mem_cs); end
    end
    cpu_ba = 1'b1;
    cyc();
    n_cmp++; if (bus_ready !== 2'b01) begin n_bad++; $display("[TB] FAIL ba_grant: got %b want 01", bus_ready); end
    hold = 2'b01; req = 2'b00;
    cyc(); hold = 2'b00;
    cyc(); cyc();
    m_last = 0;
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] oh;
    int exp;
    do_reset();
    cpu_ba = 1'b1; req = 2'b11;
    wait_grant();
    for (int b = 0; b < 4; b++) begin
      exp = b % 2;
      oh = '0; oh[exp] = 1'b1;
      n_cmp++; if (bus_ready !== oh || cpu_halt !== 1'b1) begin n_bad++; $display("[TB] FAIL rr_grant%0d: got ready=%b halt=%b want %b/1", b, bus_ready, cpu_halt, oh); end
      hold = oh; dma_addr[16*exp +: 16] = 16'($urandom); dma_cs = oh;
      cyc();
      n_cmp++; if (owner !== 2'(exp) || mem_addr !== dma_addr[16*exp +: 16]) begin n_bad++; $display("[TB] FAIL rr_own%0d: got owner=%0d addr=%h want %0d/%h", b, owner, mem_addr, exp, dma_addr[16*exp +: 16]); end
      cyc(); cyc(); cyc();
      hold = '0;
      if (b == 3) req = '0;
      cyc();
      n_cmp++; if (bus_ready !== 2'b00 || cpu_halt !== 1'b1 || mem_cs !== 1'b0) begin n_bad++; $display("[TB] FAIL rr_turn%0d: got ready=%b halt=%b cs=%b want 00/1/0", b, bus_ready, cpu_halt, mem_cs); end
      if (b < 3) cyc();
    end
    cyc();
    n_cmp++; if (cpu_halt !== 1'b0) begin n_bad++; $display("[TB] FAIL rr_release: got %b want 0", cpu_halt); end
    m_last = 1;
  endtask

  task automatic test_timeout();
    int cycles;
    cpu_ba = 1'b1; hold = '0; req = 2'b10;
    wait_grant();
    n_cmp++; if (bus_ready !== 2'b10 || timeout_err !== 1'b0) begin n_bad++; $display("[TB] FAIL to_grant: got ready=%b err=%b want 10/0", bus_ready, timeout_err); end
    cycles = 1;
    while (bus_ready != '0 && cycles < 40) begin
      cyc();
      if (bus_ready != '0) cycles++;
    end
    n_cmp++; if (cycles !== 15) begin n_bad++; $display("[TB] FAIL to_cycles: got %0d want 15", cycles); end
    n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("[TB] FAIL to_err: got %b want 1", timeout_err); end
    req = '0;
    cyc();
    n_cmp++; if (cpu_halt !== 1'b0 || timeout_err !== 1'b1) begin n_bad++; $display("[TB] FAIL to_idle: got halt=%b err=%b want 0/1", cpu_halt, timeout_err); end
  endtask

  task automatic test_reset_in_own();
    cpu_ba = 1'b1; req = 2'b01;
    wait_grant();
    n_cmp++; if (bus_ready !== 2'b01) begin n_bad++; $display("[TB] FAIL rst_grant: got %b want 01", bus_ready); end
    hold = 2'b01; dma_addr[15:0] = 16'h1234; dma_cs = 2'b01; req = '0;
    cyc();
    n_cmp++; if (mem_addr !== 16'h1234) begin n_bad++; $display("[TB] FAIL rst_own: got %h want 1234", mem_addr); end
    cpu_addr = 16'h0ABC; cpu_cs = 1'b0; rst = 1'b1;
    cyc();
    n_cmp++; if (cpu_halt !== 1'b0 || bus_ready !== 2'b00 || owner_valid !== 1'b0 || timeout_err !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_mid: got halt=%b ready=%b valid=%b err=%b want 0/00/0/0", cpu_halt, bus_ready, owner_valid, timeout_err); end
    n_cmp++; if (mem_addr !== 16'h0ABC || mem_cs !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_mem: got %h/%b want 0abc/0", mem_addr, mem_cs); end
    rst = 1'b0; hold = '0;
    m_last = NREQ - 1;
  endtask

  task automatic test_nonwinner_hold();
    cpu_ba = 1'b1; req = 2'b01;
    wait_grant();
    n_cmp++; if (bus_ready !== 2'b01) begin n_bad++; $display("[TB] FAIL nw_grant0: got %b want 01", bus_ready); end
    dma_addr = {16'hB000, 16'hA000}; dma_cs = 2'b10; hold = 2'b11; req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++; if (mem_addr !== 16'hA000 || mem_cs !== 1'b0 || bus_ready !== 2'b01) begin n_bad++; $display("[TB] FAIL nw_own0: got addr=%h cs=%b ready=%b want a000/0/01", mem_addr, mem_cs, bus_ready); end
    end
    hold = 2'b00; req = 2'b10;
    cyc();
    n_cmp++; if (bus_ready !== 2'b00) begin n_bad++; $display("[TB] FAIL nw_turn: got %b want 00", bus_ready); end
    cyc();
    n_cmp++; if (bus_ready !== 2'b10 || cpu_halt !== 1'b1) begin n_bad++; $display("[TB] FAIL nw_grant1: got ready=%b halt=%b want 10/1", bus_ready, cpu_halt); end
    hold = 2'b10; req = 2'b00;
    cyc();
    n_cmp++; if (mem_addr !== 16'hB000 || mem_cs !== 1'b1 || owner !== 2'd1) begin n_bad++; $display("[TB] FAIL nw_own1: got addr=%h cs=%b owner=%0d want b000/1/1", mem_addr, mem_cs, owner); end
    hold = '0;
    cyc(); cyc();
    m_last = 1;
  endtask

  task automatic test_random();
    logic [NREQ-1:0] pend, oh;
    logic [15:0]     a;
    logic            c;
    int              exp, len;
    do_reset();
    cpu_ba = 1'b1;
    for (int it = 0; it < 25; it++) begin
      cpu_addr = 16'($urandom); cpu_cs = 1'($urandom);
      pend = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      req = pend;
      while (pend != '0) begin
        wait_grant();
        exp = rr_next(m_last, pend);
        oh = '0; oh[exp] = 1'b1;
        n_cmp++; if (bus_ready !== oh || cpu_halt !== 1'b1) begin n_bad++; $display("[TB] FAIL rand_grant%0d: got ready=%b halt=%b want %b/1", it, bus_ready, cpu_halt, oh); end
        a = 16'($urandom); c = 1'($urandom);
        dma_addr[16*exp +: 16] = a; dma_cs[exp] = c; hold[exp] = 1'b1;
        len = $urandom_range(1, 5);
        for (int j = 0; j < len; j++) begin
          cyc();
          n_cmp++; if (mem_addr !== a || mem_cs !== c) begin n_bad++; $display("[TB] FAIL rand_own%0d: got %h/%b want %h/%b", it, mem_addr, mem_cs, a, c); end
        end
        hold[exp] = 1'b0; req[exp] = 1'b0; pend[exp] = 1'b0;
        m_last = exp;
        cyc();
      end
      cyc();
      n_cmp++; if (cpu_halt !== 1'b0 || mem_addr !== cpu_addr || mem_cs !== cpu_cs) begin n_bad++; $display("[TB] FAIL rand_idle%0d: got halt=%b addr=%h cs=%b want 0/%h/%b", it, cpu_halt, mem_addr, mem_cs, cpu_addr, cpu_cs); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ba_latency();
    test_round_robin();
    test_timeout();
    test_reset_in_own();
    test_nonwinner_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
